// File: rtl/key_led_ctrl.sv
// key_led_ctrl: single-button LED sequencer.
// The raw active-low key is synchronised, debounced into a one-cycle
// key_flag per press, and each press steps the mode FSM
// OFF -> ON -> SLOW blink -> FAST blink -> OFF.
// The FSM state is exported directly on the mode output.
// There is no handshake: key_flag is a plain one-cycle strobe with no
// acknowledge, consumed by the FSM on the following clock edge.
module key_led_ctrl #(
  parameter int CNT_DEB  = 999_999,
  parameter int CNT_SLOW = 24_999_999,
  parameter int CNT_FAST = 4_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  localparam int DEB_W   = $clog2(CNT_DEB + 1);
  localparam int BLK_MAX = (CNT_SLOW > CNT_FAST) ? CNT_SLOW : CNT_FAST;
  localparam int BLK_W   = $clog2(BLK_MAX);

  localparam logic [DEB_W-1:0] DEB_TC  = DEB_W'(CNT_DEB);
  localparam logic [DEB_W-1:0] DEB_PRE = DEB_W'(CNT_DEB - 1);
  localparam logic [BLK_W-1:0] SLOW_TC = BLK_W'(CNT_SLOW - 1);
  localparam logic [BLK_W-1:0] FAST_TC = BLK_W'(CNT_FAST - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  mode_t            state;
  mode_t            state_nxt;
  logic             key_s1;
  logic             key_s;
  logic [DEB_W-1:0] cnt_deb;
  logic [BLK_W-1:0] cnt_blk;
  logic [BLK_W-1:0] cnt_blk_nxt;
  logic [BLK_W-1:0] blk_tc;
  logic             led_nxt;

  assign mode = state;

  // Two-flop synchroniser; resets to the released (high) level so a key
  // held through reset is seen as a fresh press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s  <= key_s1;
    end
  end

  // Debounce counter: counts consecutive low samples and saturates, so a
  // held key gives exactly one key_flag; any high sample restarts it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_deb  <= '0;
      key_flag <= 1'b0;
    end else if (key_s) begin
      cnt_deb  <= '0;
      key_flag <= 1'b0;
    end else begin
      if (cnt_deb < DEB_TC) begin
        cnt_deb <= cnt_deb + DEB_W'(1);
      end
      key_flag <= (cnt_deb == DEB_PRE);
    end
  end

  // Mode state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= MODE_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next mode: advance one step per key_flag, wrapping FAST back to OFF.
  always_comb begin
    state_nxt = state;
    if (key_flag) begin
      case (state)
        MODE_OFF:  state_nxt = MODE_ON;
        MODE_ON:   state_nxt = MODE_SLOW;
        MODE_SLOW: state_nxt = MODE_FAST;
        MODE_FAST: state_nxt = MODE_OFF;
        default:   state_nxt = MODE_OFF;
      endcase
    end
  end

  // Next LED level and blink count; a mode change overrides the terminal
  // count so a press mid-blink restarts the period with the LED lit.
  always_comb begin
    led_nxt     = led_out;
    cnt_blk_nxt = '0;
    blk_tc      = (state == MODE_SLOW) ? SLOW_TC : FAST_TC;
    if (key_flag) begin
      led_nxt     = (state_nxt != MODE_OFF);
      cnt_blk_nxt = '0;
    end else begin
      case (state)
        MODE_OFF: begin
          led_nxt     = 1'b0;
          cnt_blk_nxt = '0;
        end
        MODE_ON: begin
          led_nxt     = 1'b1;
          cnt_blk_nxt = '0;
        end
        MODE_SLOW, MODE_FAST: begin
          if (cnt_blk == blk_tc) begin
            cnt_blk_nxt = '0;
            led_nxt     = ~led_out;
          end else begin
            cnt_blk_nxt = cnt_blk + BLK_W'(1);
          end
        end
        default: begin
          led_nxt     = 1'b0;
          cnt_blk_nxt = '0;
        end
      endcase
    end
  end

  // LED and blink counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_out <= 1'b0;
      cnt_blk <= '0;
    end else begin
      led_out <= led_nxt;
      cnt_blk <= cnt_blk_nxt;
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl with short counters (debounce 4, slow 8, fast 2).
// A behavioural model predicts flag/mode/led for every clock; predictions
// go into exp_q when the key is driven and are popped after the edge.
module tb_key_led_ctrl;

  localparam int CNT_DEB  = 4;
  localparam int CNT_SLOW = 8;
  localparam int CNT_FAST = 2;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_in;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  key_led_ctrl #(
    .CNT_DEB (CNT_DEB),
    .CNT_SLOW(CNT_SLOW),
    .CNT_FAST(CNT_FAST)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode     (mode),
    .key_flag (key_flag)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  // behavioural model: m_run counts consecutive raw low samples; reaching
  // CNT_DEB schedules a flag two edges later (synchroniser delay).
  int         m_run;
  logic [1:0] m_pipe;
  logic       m_flag;
  logic [1:0] m_mode;
  int         m_phase;
  logic       m_led;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_pipe  = 2'b00;
    m_flag  = 1'b0;
    m_mode  = 2'd0;
    m_phase = 0;
    m_led   = 1'b0;
  endtask

  task automatic model_step(input logic k);
    logic prev_flag;
    prev_flag = m_flag;
    m_flag    = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    if (k) m_run = 0;
    else if (m_run < 1000) m_run++;
    m_pipe[0] = (m_run == CNT_DEB);
    if (prev_flag) begin
      m_mode  = m_mode + 2'd1;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    case (m_mode)
      2'd0:    m_led = 1'b0;
      2'd1:    m_led = 1'b1;
      2'd2:    m_led = ((m_phase / CNT_SLOW) % 2) == 0;
      default: m_led = ((m_phase / CNT_FAST) % 2) == 0;
    endcase
  endtask

  // driver: one clock with key level k and reset level r, scoreboarded
  task automatic cycle(input logic k, input logic r);
    logic [3:0] e;
    @(negedge sys_clk);
    key_in    = k;
    sys_rst_n = r;
    if (!r) model_reset();
    else model_step(k);
    exp_q.push_back({m_flag, m_mode, m_led});
    @(posedge sys_clk);
    #1;
    e = exp_q.pop_front();
    check("key_flag", int'(key_flag), int'(e[3]));
    check("mode", int'(mode), int'(e[2:1]));
    check("led_out", int'(led_out), int'(e[0]));
  endtask

  typedef struct {
    logic       key;
    int         cycles;
    logic [1:0] end_mode;
    int         pulses;
    int         flag_at;
  } seg_t;

  seg_t seg[8];

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pulses;
    int first;
    int waited;

    seg[0] = '{1'b0, 30, 2'd1, 1, 6};
    seg[1] = '{1'b1, 20, 2'd1, 0, 0};
    seg[2] = '{1'b0, 10, 2'd2, 1, 6};
    seg[3] = '{1'b1, 40, 2'd2, 0, 0};
    seg[4] = '{1'b0, 10, 2'd3, 1, 6};
    seg[5] = '{1'b1, 20, 2'd3, 0, 0};
    seg[6] = '{1'b0, 10, 2'd0, 1, 6};
    seg[7] = '{1'b1, 20, 2'd0, 0, 0};

    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    model_reset();

    // reset held, then 50 idle cycles
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b1);
      if (key_flag) pulses++;
    end
    check("idle_pulses", pulses, 0);

    // bounce: 3 low / 2 high, ten times
    pulses = 0;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b1);
        if (key_flag) pulses++;
      end
      for (int i = 0; i < 2; i++) begin
        cycle(1'b1, 1'b1);
        if (key_flag) pulses++;
      end
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_mode", int'(mode), 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

    // table: clean presses through a full mode cycle
    for (int s = 0; s < 8; s++) begin
      pulses = 0;
      first  = 0;
      for (int c = 1; c <= seg[s].cycles; c++) begin
        cycle(seg[s].key, 1'b1);
        if (key_flag) begin
          pulses++;
          if (first == 0) first = c;
        end
      end
      check("seg_pulses", pulses, seg[s].pulses);
      check("seg_mode", int'(mode), int'(seg[s].end_mode));
      if (seg[s].pulses > 0) check("seg_flag_edge", first, seg[s].flag_at);
    end

    // press to ON, then to SLOW
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("slow_mode", int'(mode), 2);

    // mid-count press: align so key_flag lands with cnt_blk=5, led=0
    waited = 0;
    while (!(m_mode == 2'd2 && (m_phase % 16) == 7) && waited < 40) begin
      cycle(1'b1, 1'b1);
      waited++;
    end
    check("align_found", int'(waited < 40), 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    check("mid_flag", int'(key_flag), 1);
    check("mid_cnt_blk", int'(dut.cnt_blk), 5);
    check("mid_led", int'(led_out), 0);
    cycle(1'b0, 1'b1);
    check("mid_mode", int'(mode), 3);
    check("mid_led_entry", int'(led_out), 1);
    check("mid_cnt_restart", int'(dut.cnt_blk), 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);

    // asynchronous reset between edges while in FAST
    @(posedge sys_clk);
    #3;
    check("pre_reset_mode", int'(mode), 3);
    sys_rst_n = 1'b0;
    #1;
    check("async_led", int'(led_out), 0);
    check("async_mode", int'(mode), 0);
    check("async_flag", int'(key_flag), 0);
    model_reset();

    // key stays held across reset release: one press from OFF
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(1'b0, 1'b1);
      if (key_flag) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("held_pulses", pulses, 1);
    check("held_flag_edge", first, 6);
    check("held_mode", int'(mode), 1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
